// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: owns PC and IR and walks each instruction through
// fetch/decode/execute/memory/writeback with req/ready memory handshakes and an optional bus timeout.
module multicycle_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 16,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             writes_rd,
    input  logic             illegal,
    input  logic [XLEN-1:0]  next_pc,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      ir,
    output logic             opnd_le,
    output logic             alu_le,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic             retire,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        FAULT   = 3'd6
    } state_t;

    localparam logic [31:0]       NOP        = 32'h0000_0013;
    localparam int                WAIT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q;
    state_t            state_d;
    logic [XLEN-1:0]   pc_q;
    logic [31:0]       ir_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  cycle_q;
    logic [CNT_W-1:0]  instret_q;
    logic              waiting;
    logic              timeout_hit;

    assign waiting     = ((state_q == FETCH) && !imem_ready) || ((state_q == MEM) && !dmem_ready);
    // A ready sampled on the limit edge takes priority because the FETCH/MEM arms test ready first.
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= BOOT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (imem_ready)       state_d = DECODE;
                     else if (timeout_hit) state_d = FAULT;
            DECODE:  state_d = illegal ? FAULT : EXECUTE;
            EXECUTE: if (is_load || is_store) state_d = MEM;
                     else if (writes_rd)      state_d = WB;
                     else                     state_d = FETCH;
            MEM:     if (dmem_ready)       state_d = is_load ? WB : FETCH;
                     else if (timeout_hit) state_d = FAULT;
            WB:      state_d = FETCH;
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        opnd_le  = 1'b0;
        alu_le   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        retire   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            FETCH:   imem_req = 1'b1;
            DECODE:  opnd_le  = 1'b1;
            EXECUTE: begin
                alu_le = 1'b1;
                retire = !(is_load || is_store) && !writes_rd;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                retire   = dmem_ready && !is_load;
            end
            WB: begin
                rf_we  = 1'b1;
                retire = 1'b1;
            end
            FAULT:   fault = 1'b1;
            default: ;
        endcase
    end

    // The wait counter restarts whenever the state moves, so each request gets its own budget.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= NOP;
            wait_q    <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if ((state_q == FETCH) && imem_ready) ir_q <= imem_rdata;
            if (retire) begin
                pc_q      <= next_pc;
                instret_q <= instret_q + CNT_W'(1);
            end
            if (state_d != state_q) wait_q <= '0;
            else if (waiting)       wait_q <= wait_q + WAIT_W'(1);
            if ((state_q != BOOT) && (state_q != FAULT)) cycle_q <= cycle_q + CNT_W'(1);
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign ir          = ir_q;
    assign state       = state_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: retire expectations are queued when an instruction
// is launched and popped when the DUT pulses retire.
module tb_multicycle_sequencer;

    localparam int          XLEN    = 32;
    localparam int          TIMEOUT = 4;
    localparam int          CNT_W   = 4;
    localparam int          CMASK   = (1 << CNT_W) - 1;
    localparam logic [31:0] ADDI    = 32'h0010_0093;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_ready = 1'b0;
    logic [31:0]      imem_rdata = '0;
    logic             is_load = 1'b0;
    logic             is_store = 1'b0;
    logic             writes_rd = 1'b0;
    logic             illegal = 1'b0;
    logic [XLEN-1:0]  next_pc = '0;
    logic [XLEN-1:0]  pc;
    logic [31:0]      ir;
    logic             opnd_le;
    logic             alu_le;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ready = 1'b0;
    logic             rf_we;
    logic             retire;
    logic             fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    multicycle_sequencer #(
        .XLEN(XLEN), .RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .is_load(is_load), .is_store(is_store), .writes_rd(writes_rd), .illegal(illegal),
        .next_pc(next_pc), .pc(pc), .ir(ir), .opnd_le(opnd_le), .alu_le(alu_le),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .rf_we(rf_we), .retire(retire), .fault(fault), .state(state),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc_after;
        logic [31:0] instret;
        logic [31:0] cycle_cnt;
        logic [31:0] ir_val;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] pc_model = '0;
    int          instret_model = 0;
    int          cycle_model = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset(input int n);
        rst        = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        writes_rd  = 1'b0;
        illegal    = 1'b0;
        next_pc    = '0;
        imem_rdata = '0;
        repeat (n) @(negedge clk);
        #1;
        checkOutput("rst_state",   32'(state), 32'd0);
        checkOutput("rst_pc",      pc, 32'h0);
        checkOutput("rst_ir",      ir, 32'h0000_0013);
        checkOutput("rst_cycle",   32'(cycle_cnt), 32'd0);
        checkOutput("rst_instret", 32'(instret_cnt), 32'd0);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_retire",  32'(retire), 32'd0);
        checkOutput("rst_fault",   32'(fault), 32'd0);
        rst           = 1'b1;
        pc_model      = '0;
        instret_model = 0;
        cycle_model   = 0;
    endtask

    task automatic bootToFetch();
        @(negedge clk);
        #1;
        checkOutput("boot_to_fetch", 32'(state), 32'd1);
    endtask

    // Runs one instruction from FETCH to retire; fw/mw are ready-low cycles on the fetch/data side.
    task automatic applyStimulus(input logic ld, input logic st, input logic wr,
                                 input logic [31:0] npc, input logic [31:0] rdata,
                                 input int fw, input int mw, input int exp_cycles);
        exp_t e;
        int   cycles = 0;
        int   fcnt = 0;
        int   mcnt = 0;
        int   rfw = 0;
        logic done = 1'b0;
        e.pc_after  = npc;
        e.instret   = 32'((instret_model + 1) & CMASK);
        e.cycle_cnt = 32'((cycle_model + exp_cycles) & CMASK);
        e.ir_val    = rdata;
        e.cycles    = exp_cycles;
        sb.push_back(e);
        is_load   = ld;
        is_store  = st;
        writes_rd = wr;
        illegal   = 1'b0;
        next_pc   = npc;
        while (!done && cycles < 40) begin
            imem_ready = (state == 3'd1) ? (fcnt >= fw) : 1'b1;
            imem_rdata = (state == 3'd1) ? rdata : 32'hDEAD_BEEF;
            dmem_ready = (state == 3'd4) ? (mcnt >= mw) : 1'b1;
            #1;
            if (state == 3'd1) begin
                checkOutput("fetch_addr", imem_addr, pc_model);
                fcnt++;
            end
            if (state == 3'd4) begin
                checkOutput("dmem_we", 32'(dmem_we), 32'(st));
                mcnt++;
            end
            if (rf_we) rfw++;
            cycles++;
            done = retire;
            @(negedge clk);
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        checkOutput("retire_seen", 32'(done), 32'd1);
        e = sb.pop_front();
        checkOutput("latency",     cycles, e.cycles);
        checkOutput("pc_after",    pc, e.pc_after);
        checkOutput("instret",     32'(instret_cnt), e.instret);
        checkOutput("cycle_cnt",   32'(cycle_cnt), e.cycle_cnt);
        checkOutput("ir_held",     ir, e.ir_val);
        checkOutput("rf_we_count", rfw, (wr && !st) ? 32'd1 : 32'd0);
        checkOutput("dmem_cycles", mcnt, (ld || st) ? 32'(mw + 1) : 32'd0);
        checkOutput("back_to_fetch", 32'(state), 32'd1);
        pc_model      = npc;
        instret_model = (instret_model + 1) & CMASK;
        cycle_model   = (cycle_model + exp_cycles) & CMASK;
    endtask

    initial begin
        int seq[5] = '{1, 2, 3, 5, 1};

        $display("[TB] reset then ALU op");
        doReset(2);
        imem_ready = 1'b1;
        imem_rdata = ADDI;
        writes_rd  = 1'b1;
        next_pc    = 32'h4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("alu_state%0d", i), 32'(state), seq[i]);
            if (i == 1) checkOutput("alu_ir", ir, ADDI);
            if (i == 3) begin
                checkOutput("alu_rf_we", 32'(rf_we), 32'd1);
                checkOutput("alu_retire", 32'(retire), 32'd1);
            end
            if (i == 4) begin
                checkOutput("alu_rf_we_off", 32'(rf_we), 32'd0);
                checkOutput("alu_pc", pc, 32'h4);
                checkOutput("alu_instret", 32'(instret_cnt), 32'd1);
            end
        end
        @(negedge clk);
        #1;
        checkOutput("alu_cycle_cnt", 32'(cycle_cnt), 32'd5);

        $display("[TB] mixed instruction stream");
        doReset(1);
        bootToFetch();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h04, 32'h0010_0093, 1, 0, 5);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h08, 32'h0000_2103, 0, 3, 8);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0C, 32'h0020_2023, 0, 0, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0030_2223, 2, 1, 7);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h40, 32'h0200_0063, 0, 0, 3);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h44, 32'h0040_2183, 3, 0, 8);

        $display("[TB] counter wrap");
        doReset(1);
        bootToFetch();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, pc_model + 32'h4, 32'h0000_0063, 0, 0, 3);
            if (i == 14) checkOutput("wrap_at_15", 32'(instret_cnt), 32'd15);
        end
        checkOutput("wrap_to_0", 32'(instret_cnt), 32'd0);
        checkOutput("wrap_pc", pc, 32'h40);

        $display("[TB] fetch timeout");
        doReset(1);
        bootToFetch();
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b0;
            @(negedge clk);
            #1;
            checkOutput("to_waiting", 32'(state), 32'd1);
        end
        @(negedge clk);
        #1;
        checkOutput("to_state", 32'(state), 32'd6);
        checkOutput("to_fault", 32'(fault), 32'd1);
        checkOutput("to_imem_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("to_sticky", 32'(fault), 32'd1);
        checkOutput("to_req_held_off", 32'(imem_req), 32'd0);

        $display("[TB] ready on last allowed cycle");
        doReset(1);
        bootToFetch();
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b0;
            @(negedge clk);
            #1;
        end
        imem_ready = 1'b1;
        imem_rdata = ADDI;
        @(negedge clk);
        #1;
        checkOutput("late_ready_state", 32'(state), 32'd2);
        checkOutput("late_ready_fault", 32'(fault), 32'd0);

        $display("[TB] illegal instruction");
        doReset(1);
        bootToFetch();
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        illegal    = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("ill_decode", 32'(state), 32'd2);
        checkOutput("ill_opnd_le", 32'(opnd_le), 32'd1);
        imem_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("ill_state", 32'(state), 32'd6);
        checkOutput("ill_fault", 32'(fault), 32'd1);
        repeat (2) begin
            @(negedge clk);
            #1;
            checkOutput("ill_retire", 32'(retire), 32'd0);
            checkOutput("ill_cycle_frozen", 32'(cycle_cnt), 32'd2);
            checkOutput("ill_instret", 32'(instret_cnt), 32'd0);
            checkOutput("ill_no_req", 32'(imem_req | dmem_req), 32'd0);
        end

        $display("[TB] reset in the middle of a load");
        doReset(1);
        bootToFetch();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h40, 32'h0200_0063, 0, 0, 3);
        is_load    = 1'b1;
        writes_rd  = 1'b1;
        next_pc    = 32'h80;
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_2103;
        dmem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("mid_mem_state", 32'(state), 32'd4);
        checkOutput("mid_mem_req", 32'(dmem_req), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("mid_rst_state", 32'(state), 32'd0);
        checkOutput("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("mid_rst_pc", pc, 32'h0);
        checkOutput("mid_rst_fault", 32'(fault), 32'd0);
        checkOutput("mid_rst_retire", 32'(retire), 32'd0);
        checkOutput("mid_rst_instret", 32'(instret_cnt), 32'd0);
        rst = 1'b1;
        imem_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("recover_fetch", 32'(state), 32'd1);
        checkOutput("recover_addr", imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Parametrised multi-cycle control sequencer: successor to the single-cycle core's implicit one-instruction-per-clock control.
- Owns PC and instruction register, and steps each instruction through fetch/decode/execute/memory/writeback.
- Talks to instruction and data memory over req/ready handshakes of arbitrary latency, with an optional bus timeout.
- Sits between the existing decoder (CU), which classifies the held instruction combinationally, and the datapath enables.

Parameters:
- XLEN, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max wait cycles for ready per request; 0 disables timeout.
- CNT_W, 32, width of the cycle and instret counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address, equals pc.
- imem_ready  in  1  fetch data valid.
- imem_rdata  in  32  fetched instruction.
- is_load  in  1  CU class of ir.
- is_store  in  1  CU class of ir.
- writes_rd  in  1  ir writes rd (ALU, load, jal/jalr, lui/auipc, csr).
- illegal  in  1  ir undecodable.
- next_pc  in  XLEN  from PC_update.
- pc  out  XLEN  current PC.
- ir  out  32  held instruction.
- opnd_le  out  1  latch rs1/rs2/imm (DECODE).
- alu_le  out  1  latch ALU result (EXECUTE).
- dmem_req  out  1  data access request.
- dmem_we  out  1  store when dmem_req.
- dmem_ready  in  1  data access done.
- rf_we  out  1  register write pulse.
- retire  out  1  instruction complete pulse.
- fault  out  1  sticky fault.
- state  out  3  encoded state for debug.
- cycle_cnt  out  CNT_W  running cycles.
- instret_cnt  out  CNT_W  retired instructions.

Behaviour:
Reset (rst=0 at a rising edge):
- State becomes BOOT, pc=RESET_PC, ir=32'h00000013 (NOP), both counters 0, wait counter 0.
- All strobes and requests are 0; fault=0.
- Reset mid-transaction drops req on the next cycle with no retire.

States and transitions:
- BOOT=0: one idle cycle, then FETCH.
- FETCH=1: imem_req=1, imem_addr=pc.
  - On a rising edge with imem_ready=1: ir<=imem_rdata, go to DECODE.
- DECODE=2: opnd_le=1.
  - If illegal=1, go to FAULT; otherwise go to EXECUTE.
- EXECUTE=3: alu_le=1.
  - is_load|is_store: go to MEM.
  - Else writes_rd: go to WB.
  - Else: retire.
- MEM=4: dmem_req=1, dmem_we=is_store.
  - On dmem_ready=1: a load goes to WB; a store retires.
- WB=5: rf_we=1 for exactly one cycle, then retire.
- FAULT=6: fault=1, no requests; exits only via reset.

Retire:
- retire=1 for one cycle, in the last cycle of the instruction (EXECUTE, MEM-with-ready, or WB).
- On that edge: pc<=next_pc, go to FETCH, instret_cnt+=1.

Latency without waits:
- ALU op: 4 cycles (F,D,E,WB).
- Branch: 3 cycles.
- Store: 4 cycles.
- Load: 5 cycles.
- Each ready-low cycle adds 1.

Handshake:
- req stays high, with address and we stable, until ready is sampled high.
- ready while req=0 is ignored.
- ready high in the first req cycle completes with zero wait.

Timeout:
- The wait counter increments each FETCH/MEM cycle with ready=0 and clears on state change.
- When TIMEOUT≠0 and the counter reaches TIMEOUT-1 with ready still 0, go to FAULT on that edge.
- Ready arriving on that same edge wins: the transfer completes, no fault.

Counters:
- cycle_cnt increments every cycle except reset, BOOT and FAULT.
- Both counters wrap modulo 2^CNT_W silently.

Ordering and stability:
- ir and pc change only on the edges stated above.
- Class inputs are sampled only in DECODE, EXECUTE and MEM.

Test Plan:
- Reset then ALU op: rst low 2 cycles, imem_ready tied 1, ir=ADDI (writes_rd=1) -> states 0,1,2,3,5,1. rf_we high 1 cycle in WB; pc 0→4 on the retire edge; instret_cnt=1; cycle_cnt=5 at retire+1.
- Load with waits: is_load=1, dmem_ready low 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB; total 8 cycles from FETCH to retire.
- Store and branch: is_store=1 -> retire in MEM, rf_we never high. Branch with next_pc=0x40 -> retire in EXECUTE, pc=0x40, then FETCH addr 0x40.
- Timeout: TIMEOUT=4, imem_ready held 0 -> fault=1 after 4 FETCH cycles, state=6, imem_req=0 thereafter. Ready on the 4th cycle instead -> no fault, DECODE.
- Illegal and reset recovery: illegal=1 in DECODE -> FAULT, no retire. rst low one cycle mid-MEM -> BOOT, dmem_req 0, pc=RESET_PC, fault 0.
- Counter wrap: CNT_W=4, 16 back-to-back branches -> instret_cnt goes 15→0 without side effects.
